// File: rtl/irq_priority_arbiter.sv
// Fixed-priority interrupt arbiter: edge-detects N_SRC lines, presents one
// request with its cause code, and tracks a single in-service interrupt.
module irq_priority_arbiter #(
  parameter int          N_SRC      = 8,
  parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_SRC-1:0]         irq_lines_i,
  input  logic [N_SRC-1:0]         irq_mask_i,
  input  logic                     irq_ack_i,
  input  logic                     irq_ret_i,
  output logic                     irq_req_o,
  output logic [31:0]              irq_cause_o,
  output logic [$clog2(N_SRC)-1:0] irq_id_o,
  output logic                     busy_o,
  output logic [N_SRC-1:0]         pending_o
);

  localparam int IW = $clog2(N_SRC);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]       state;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] prev_lines;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] masked;
  logic [N_SRC-1:0] clr;
  logic [IW-1:0]    id;
  logic [IW-1:0]    sel;
  logic             any;

  always_comb begin
    rise   = irq_lines_i & ~prev_lines;
    masked = pending & irq_mask_i;
    any    = |masked;
    sel    = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (masked[k]) sel = IW'(k);
    end
    clr = '0;
    if (state == REQ && irq_ack_i) clr[id] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      pending    <= '0;
      prev_lines <= '0;
      id         <= '0;
    end else begin
      prev_lines <= irq_lines_i;
      // a rise on the acceptance cycle survives the clear
      pending    <= (pending & ~clr) | rise;
      case (state)
        IDLE: begin
          if (any) begin
            state <= REQ;
            id    <= sel;
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            state <= SERVICE;
          end else if (any) begin
            id <= sel;
          end else begin
            state <= IDLE;
          end
        end
        SERVICE: begin
          if (irq_ret_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign irq_req_o   = (state == REQ);
  assign busy_o      = (state == SERVICE);
  assign irq_id_o    = id;
  assign irq_cause_o = CAUSE_BASE + 32'(id);
  assign pending_o   = pending;

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Bench for irq_priority_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_irq_priority_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  irq_lines_i;
  logic [7:0]  irq_mask_i;
  logic        irq_ack_i;
  logic        irq_ret_i;
  logic        irq_req_o;
  logic [31:0] irq_cause_o;
  logic [2:0]  irq_id_o;
  logic        busy_o;
  logic [7:0]  pending_o;

  irq_priority_arbiter dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .irq_lines_i (irq_lines_i),
    .irq_mask_i  (irq_mask_i),
    .irq_ack_i   (irq_ack_i),
    .irq_ret_i   (irq_ret_i),
    .irq_req_o   (irq_req_o),
    .irq_cause_o (irq_cause_o),
    .irq_id_o    (irq_id_o),
    .busy_o      (busy_o),
    .pending_o   (pending_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  // model: 0 waiting, 1 requesting, 2 in service
  int       m_mode;
  int       m_id;
  bit [7:0] m_pend;
  bit [7:0] m_prev;

  function automatic int pick(bit [7:0] p, bit [7:0] m);
    for (int k = 0; k < 8; k++)
      if (p[k] && m[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_id   = 0;
    m_pend = '0;
    m_prev = '0;
  endtask

  task automatic model_step(bit [7:0] ln, bit [7:0] mk, bit ack, bit ret);
    int       s;
    bit [7:0] np;
    s  = pick(m_pend, mk);
    np = m_pend;
    if (m_mode == 0) begin
      if (s >= 0) begin
        m_mode = 1;
        m_id   = s;
      end
    end else if (m_mode == 1) begin
      if (ack) begin
        np[m_id] = 1'b0;
        m_mode   = 2;
      end else if (s >= 0) begin
        m_id = s;
      end else begin
        m_mode = 0;
      end
    end else if (ret) begin
      m_mode = 0;
    end
    m_pend = np | (ln & ~m_prev);
    m_prev = ln;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare();
    check("req", 32'(irq_req_o), 32'(m_mode == 1));
    check("busy", 32'(busy_o), 32'(m_mode == 2));
    check("id", 32'(irq_id_o), 32'(m_id));
    check("cause", irq_cause_o, 32'h8000_0010 + 32'(m_id));
    check("pending", 32'(pending_o), 32'(m_pend));
  endtask

  // called at a negedge; returns at the next negedge after comparing
  task automatic tick(bit [7:0] ln, bit [7:0] mk, bit ack, bit ret);
    irq_lines_i = ln;
    irq_mask_i  = mk;
    irq_ack_i   = ack;
    irq_ret_i   = ret;
    @(posedge clk_i);
    if (!rst_ni) model_reset();
    else model_step(ln, mk, ack, ret);
    @(negedge clk_i);
    compare();
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    irq_lines_i = '0;
    irq_ack_i   = 1'b0;
    irq_ret_i   = 1'b0;
    #1;
    model_reset();
    compare();
    check("rst_req", 32'(irq_req_o), 32'd0);
    check("rst_cause", irq_cause_o, 32'h8000_0010);
    tick(8'h00, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 0, 0);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    irq_lines_i = '0;
    irq_mask_i  = 8'hFF;
    irq_ack_i   = 1'b0;
    irq_ret_i   = 1'b0;
    model_reset();
    @(negedge clk_i);
    compare();
    check("reset_busy", 32'(busy_o), 32'd0);
    tick(8'h00, 8'hFF, 0, 0);
    rst_ni = 1'b1;

    // single source
    tick(8'h08, 8'hFF, 0, 0);
    check("t1_pend", 32'(pending_o), 32'h08);
    tick(8'h00, 8'hFF, 0, 0);
    check("t1_req", 32'(irq_req_o), 32'd1);
    check("t1_cause", irq_cause_o, 32'h8000_0013);
    tick(8'h00, 8'hFF, 1, 0);
    check("t1_busy", 32'(busy_o), 32'd1);
    check("t1_clr", 32'(pending_o), 32'h00);
    tick(8'h00, 8'hFF, 0, 1);
    check("t1_idle", 32'(busy_o), 32'd0);

    // priority
    tick(8'h24, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 0, 0);
    check("t2_cause", irq_cause_o, 32'h8000_0012);
    tick(8'h00, 8'hFF, 1, 0);
    tick(8'h00, 8'hFF, 0, 1);
    check("t2_gap", 32'(irq_req_o), 32'd0);
    tick(8'h00, 8'hFF, 0, 0);
    check("t2_id5", 32'(irq_id_o), 32'd5);
    tick(8'h00, 8'hFF, 1, 0);
    tick(8'h00, 8'hFF, 0, 1);
    check("t2_empty", 32'(pending_o), 32'h00);

    // re-target
    tick(8'h40, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 0, 0);
    check("t3_id6", 32'(irq_id_o), 32'd6);
    tick(8'h02, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 0, 0);
    check("t3_id1", 32'(irq_id_o), 32'd1);
    tick(8'h00, 8'hFF, 1, 0);
    check("t3_pend", 32'(pending_o), 32'h40);
    tick(8'h00, 8'hFF, 0, 1);
    tick(8'h00, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 1, 0);
    tick(8'h00, 8'hFF, 0, 1);

    // masking
    tick(8'h10, 8'hEF, 0, 0);
    tick(8'h00, 8'hEF, 0, 0);
    tick(8'h00, 8'hEF, 0, 0);
    check("t4_noreq", 32'(irq_req_o), 32'd0);
    tick(8'h00, 8'hFF, 0, 0);
    check("t4_req", 32'(irq_req_o), 32'd1);
    tick(8'h00, 8'hEF, 0, 0);
    check("t4_drop", 32'(irq_req_o), 32'd0);
    check("t4_kept", 32'(pending_o), 32'h10);
    tick(8'h00, 8'hFF, 0, 0);
    check("t4_id4", 32'(irq_id_o), 32'd4);
    tick(8'h00, 8'hFF, 1, 0);
    tick(8'h00, 8'hFF, 0, 1);

    // boundaries
    tick(8'h01, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 1, 0);
    tick(8'h01, 8'hFF, 0, 0);
    check("t5_svc_pend", 32'(pending_o), 32'h01);
    tick(8'h00, 8'hFF, 0, 1);
    tick(8'h00, 8'hFF, 0, 0);
    check("t5_rereq", 32'(irq_req_o), 32'd1);
    tick(8'h01, 8'hFF, 1, 0);
    check("t5_ackrise", 32'(pending_o), 32'h01);
    tick(8'h00, 8'hFF, 0, 1);
    tick(8'h00, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 1, 0);
    tick(8'h00, 8'hFF, 0, 1);
    tick(8'h00, 8'hFF, 1, 0);
    check("t5_stray_ack", 32'(irq_req_o | busy_o), 32'd0);
    tick(8'h04, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 0, 1);
    check("t5_stray_ret", 32'(irq_req_o), 32'd1);
    tick(8'h00, 8'hFF, 1, 1);
    check("t5_ackret", 32'(busy_o), 32'd1);
    tick(8'h00, 8'hFF, 0, 1);

    // reset in service, then in request
    tick(8'h80, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 1, 0);
    do_reset();
    tick(8'h20, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 0, 0);
    do_reset();
    tick(8'h00, 8'hFF, 0, 0);
    tick(8'h00, 8'hFF, 0, 0);
    check("t6_quiet", 32'(irq_req_o), 32'd0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit [7:0] ln;
      bit [7:0] mk;
      ln = 8'($urandom & $urandom & $urandom);
      mk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick(ln, mk, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
